// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: RV32I major opcodes, forwarding
// select encodings and a small opcode decoder used at the ID stage.
package hazard_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
        logic is_load;
    } decode_t;

    // Unknown opcodes read nothing and write nothing, so they can never hazard.
    function automatic decode_t decode_op(input logic [6:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_R:     begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.writes_rd = 1'b1; end
            OP_I:     begin d.use_rs1 = 1'b1; d.writes_rd = 1'b1; end
            OP_L:     begin d.use_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_load = 1'b1; end
            OP_S:     begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OP_B:     begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            OP_J:     d.writes_rd = 1'b1;
            OP_JALR:  begin d.use_rs1 = 1'b1; d.writes_rd = 1'b1; end
            OP_LUI:   d.writes_rd = 1'b1;
            OP_AUIPC: d.writes_rd = 1'b1;
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shift register of in-flight destination tags (entry 0 = EX) with per-stage
// match flags for two source registers.
module hazard_tag_pipe #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PIPE_DEPTH     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      insert,
    input  logic [REG_ADDR_WIDTH-1:0] ins_rd,
    input  logic                      ins_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [PIPE_DEPTH-1:0]     match_rs1,
    output logic [PIPE_DEPTH-1:0]     match_rs2,
    output logic [PIPE_DEPTH-1:0]     is_load
);

    logic [PIPE_DEPTH-1:0]     valid_q;
    logic [PIPE_DEPTH-1:0]     load_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q [PIPE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            load_q  <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) rd_q[k] <= '0;
        end else begin
            valid_q <= {valid_q[PIPE_DEPTH-2:0], insert};
            load_q  <= {load_q[PIPE_DEPTH-2:0], insert & ins_is_load};
            rd_q[0] <= ins_rd;
            for (int k = 1; k < PIPE_DEPTH; k++) rd_q[k] <= rd_q[k-1];
        end
    end

    // x0 is never tracked as a producer nor considered as a consumer.
    always_comb begin
        match_rs1 = '0;
        match_rs2 = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            match_rs1[k] = valid_q[k] && (rd_q[k] == rs1) && (rs1 != '0);
            match_rs2[k] = valid_q[k] && (rd_q[k] == rs2) && (rs2 != '0);
        end
    end

    assign is_load = load_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-side hazard unit: decodes the ID opcode, tracks in-flight writes and
// produces stall/flush plus EX-aligned registered forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PIPE_DEPTH     = 3,
    parameter int FORWARD        = 1,
    parameter int RF_BYPASS      = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [6:0]                id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      ex_redirect,
    output logic                      flush,
    output logic                      stall,
    output logic [1:0]                ex_fwd_rs1,
    output logic [1:0]                ex_fwd_rs2,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    decode_t               dec;
    logic                  issue;
    logic                  insert;
    logic                  hazard;
    logic [PIPE_DEPTH-1:0] raw_m1, raw_m2, m1, m2, ld;

    assign dec = decode_op(id_opcode);

    assign issue  = id_valid & ~stall & ~flush;
    assign insert = issue & dec.writes_rd & (id_rd != '0);

    hazard_tag_pipe #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .PIPE_DEPTH     (PIPE_DEPTH)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .insert      (insert),
        .ins_rd      (id_rd),
        .ins_is_load (dec.is_load),
        .rs1         (id_rs1),
        .rs2         (id_rs2),
        .match_rs1   (raw_m1),
        .match_rs2   (raw_m2),
        .is_load     (ld)
    );

    assign m1 = raw_m1 & {PIPE_DEPTH{dec.use_rs1}};
    assign m2 = raw_m2 & {PIPE_DEPTH{dec.use_rs2}};

    function automatic logic stage_stalls(input int k, input logic is_ld);
        if (RF_BYPASS != 0 && k == PIPE_DEPTH - 1) return 1'b0;
        if (FORWARD == 0) return 1'b1;
        if (k == 0) return is_ld;
        if (k == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Walk oldest to youngest so the youngest matching producer wins.
    function automatic logic src_stalls(input logic [PIPE_DEPTH-1:0] m,
                                        input logic [PIPE_DEPTH-1:0] l);
        logic s;
        s = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--)
            if (m[k]) s = stage_stalls(k, l[k]);
        return s;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [PIPE_DEPTH-1:0] m);
        logic [1:0] f;
        f = FWD_RF;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--)
            if (m[k]) f = (k == 0) ? FWD_EXMEM : (k == 1) ? FWD_MEMWB : FWD_RF;
        return f;
    endfunction

    assign hazard = src_stalls(m1, ld) | src_stalls(m2, ld);
    assign flush  = ex_redirect & ~rst;
    assign stall  = id_valid & hazard & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_fwd_rs1 <= FWD_RF;
            ex_fwd_rs2 <= FWD_RF;
        end else if (issue && FORWARD != 0) begin
            ex_fwd_rs1 <= fwd_sel(m1);
            ex_fwd_rs2 <= fwd_sel(m2);
        end else begin
            ex_fwd_rs1 <= FWD_RF;
            ex_fwd_rs2 <= FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(stall);
            flush_cnt <= flush_cnt + CNT_WIDTH'(flush);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three configurations (forwarding,
// no-forwarding, no-forwarding with regfile bypass) driven one at a time.
module tb_hazard_scoreboard;

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] L_OP = 7'b0000011;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect;
    int         sel;

    logic [2:0]  v_w, r_w;
    logic [2:0]  stall_w, flush_w;
    logic [1:0]  f1_w [3];
    logic [1:0]  f2_w [3];
    logic [31:0] scnt_w [3];
    logic [31:0] fcnt_w [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees valid instructions and redirects.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            v_w[i] = id_valid & (sel == i);
            r_w[i] = ex_redirect & (sel == i);
        end
    end

    hazard_scoreboard #(.FORWARD(1), .RF_BYPASS(0)) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(v_w[0]), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(r_w[0]),
        .flush(flush_w[0]), .stall(stall_w[0]), .ex_fwd_rs1(f1_w[0]), .ex_fwd_rs2(f2_w[0]),
        .stall_cnt(scnt_w[0]), .flush_cnt(fcnt_w[0])
    );

    hazard_scoreboard #(.FORWARD(0), .RF_BYPASS(0)) dut_nofwd (
        .clk(clk), .rst(rst), .id_valid(v_w[1]), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(r_w[1]),
        .flush(flush_w[1]), .stall(stall_w[1]), .ex_fwd_rs1(f1_w[1]), .ex_fwd_rs2(f2_w[1]),
        .stall_cnt(scnt_w[1]), .flush_cnt(fcnt_w[1])
    );

    hazard_scoreboard #(.FORWARD(0), .RF_BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .id_valid(v_w[2]), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(r_w[2]),
        .flush(flush_w[2]), .stall(stall_w[2]), .ex_fwd_rs1(f1_w[2]), .ex_fwd_rs2(f2_w[2]),
        .stall_cnt(scnt_w[2]), .flush_cnt(fcnt_w[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one ID cycle at negedge, then check stall/flush for this cycle and
    // the forwarding selects registered at the previous edge.
    task automatic step(input logic r, input logic v, input logic [6:0] op,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic redir, input logic es, input logic ef,
                        input logic [1:0] e1, input logic [1:0] e2, input string tag);
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = op;
        id_rs1 = s1; id_rs2 = s2; id_rd = d; ex_redirect = redir;
        #1;
        check({tag, " stall"}, 32'(stall_w[sel]), 32'(es));
        check({tag, " flush"}, 32'(flush_w[sel]), 32'(ef));
        check({tag, " fwd1"},  32'(f1_w[sel]),    32'(e1));
        check({tag, " fwd2"},  32'(f2_w[sel]),    32'(e2));
    endtask

    task automatic idle(input logic [1:0] e1, input logic [1:0] e2, input string tag);
        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e2, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) idle(2'b00, 2'b00, "drain");
    endtask

    initial begin
        sel = 0;
        rst = 1'b1; id_valid = 1'b0; id_opcode = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst stall", 32'(stall_w[i]), 32'd0);
            check("rst flush", 32'(flush_w[i]), 32'd0);
            check("rst fwd1",  32'(f1_w[i]),    32'd0);
            check("rst fwd2",  32'(f2_w[i]),    32'd0);
            check("rst scnt",  scnt_w[i],       32'd0);
            check("rst fcnt",  fcnt_w[i],       32'd0);
        end

        // Forwarding config: EX/MEM forward, load-use, x0, flush.
        sel = 0;
        step(0, 1, R_OP, 5'd1, 5'd2, 5'd5, 0, 0, 0, 2'b00, 2'b00, "s1 add x5");
        step(0, 1, R_OP, 5'd5, 5'd1, 5'd6, 0, 0, 0, 2'b00, 2'b00, "s1 add x6");
        idle(2'b01, 2'b00, "s1 ex");
        drain();
        step(0, 1, L_OP, 5'd1, 5'd2, 5'd5, 0, 0, 0, 2'b00, 2'b00, "s2 lw x5");
        step(0, 1, R_OP, 5'd5, 5'd5, 5'd6, 0, 1, 0, 2'b00, 2'b00, "s2 use stall");
        step(0, 1, R_OP, 5'd5, 5'd5, 5'd6, 0, 0, 0, 2'b00, 2'b00, "s2 use issue");
        idle(2'b10, 2'b10, "s2 ex");
        check("s2 scnt", scnt_w[0], 32'd1);
        step(0, 1, I_OP, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, "s4 addi x0");
        step(0, 1, R_OP, 5'd0, 5'd0, 5'd1, 0, 0, 0, 2'b00, 2'b00, "s4 add x1");
        idle(2'b00, 2'b00, "s4 ex");
        drain();
        step(0, 1, L_OP, 5'd1, 5'd2, 5'd5, 0, 0, 0, 2'b00, 2'b00, "s5 lw x5");
        step(0, 1, R_OP, 5'd5, 5'd5, 5'd6, 1, 0, 1, 2'b00, 2'b00, "s5 redirect");
        idle(2'b00, 2'b00, "s5 ex");
        check("s5 fcnt", fcnt_w[0], 32'd1);
        check("s5 scnt", scnt_w[0], 32'd1);

        // No forwarding, no bypass: three stall cycles.
        sel = 1;
        step(0, 1, R_OP, 5'd1, 5'd2, 5'd5, 0, 0, 0, 2'b00, 2'b00, "s3 add x5");
        for (int i = 0; i < 3; i++)
            step(0, 1, R_OP, 5'd5, 5'd2, 5'd7, 0, 1, 0, 2'b00, 2'b00, "s3 sub stall");
        step(0, 1, R_OP, 5'd5, 5'd2, 5'd7, 0, 0, 0, 2'b00, 2'b00, "s3 sub issue");
        idle(2'b00, 2'b00, "s3 ex");
        check("s3 scnt", scnt_w[1], 32'd3);

        // No forwarding, regfile bypass: two stall cycles.
        sel = 2;
        step(0, 1, R_OP, 5'd1, 5'd2, 5'd5, 0, 0, 0, 2'b00, 2'b00, "s3b add x5");
        for (int i = 0; i < 2; i++)
            step(0, 1, R_OP, 5'd5, 5'd2, 5'd7, 0, 1, 0, 2'b00, 2'b00, "s3b sub stall");
        step(0, 1, R_OP, 5'd5, 5'd2, 5'd7, 0, 0, 0, 2'b00, 2'b00, "s3b sub issue");
        idle(2'b00, 2'b00, "s3b ex");
        check("s3b scnt", scnt_w[2], 32'd2);

        // Reset in the middle of a stall drops the in-flight producer.
        sel = 1;
        drain();
        step(0, 1, R_OP, 5'd1, 5'd2, 5'd5, 0, 0, 0, 2'b00, 2'b00, "s6 add x5");
        step(0, 1, R_OP, 5'd5, 5'd2, 5'd7, 0, 1, 0, 2'b00, 2'b00, "s6 sub stall");
        step(1, 1, R_OP, 5'd5, 5'd2, 5'd7, 1, 0, 0, 2'b00, 2'b00, "s6 in rst");
        step(0, 1, R_OP, 5'd5, 5'd2, 5'd7, 0, 0, 0, 2'b00, 2'b00, "s6 post rst");
        check("s6 scnt", scnt_w[1], 32'd0);
        check("s6 fcnt", fcnt_w[1], 32'd0);
        idle(2'b00, 2'b00, "s6 ex");
        check("s6 scnt end", scnt_w[1], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
